// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: round-robin sharing of one single-cycle sigmoid evaluator
// among NUM_REQ requesters. Only one operation is in flight at a time. Each
// result is steered back by tag into a per-requester response register that
// has a valid/ready handoff.
// Optional build macro SIGMOID_ARB_STATS_EN adds saturating grant/busy counters.
module sigmoid_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         sig_in,
  input  logic [DATA_W-1:0]         sig_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready
`ifdef SIGMOID_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grants,
  output logic [15:0]               stat_busy
`endif
);

  logic [TAG_W-1:0]  last_gnt_q, last_gnt_d;
  logic              inflight_v_q, inflight_v_d;
  logic [TAG_W-1:0]  inflight_tag_q, inflight_tag_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q [NUM_REQ];
  logic [DATA_W-1:0] rsp_data_d [NUM_REQ];

  logic [NUM_REQ-1:0] elig_s;
  logic               gnt_v_s;
  logic [TAG_W-1:0]   gnt_idx_s;

  // A requester is eligible when it has an operand, its response slot will be
  // free, and it does not already own the in-flight operation.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = req_valid[i]
                & (~rsp_valid_q[i] | rsp_ready[i])
                & ~(inflight_v_q & (inflight_tag_q == TAG_W'(i)));
    end
  end

  // Round-robin search starting one past the last grant; nothing is granted in reset.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_v_s   = 1'b0;
    gnt_idx_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_gnt_q) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!reset && !gnt_v_s && (i == idx) && elig_s[i]) begin
          gnt_v_s   = 1'b1;
          gnt_idx_s = TAG_W'(i);
        end else begin
          gnt_v_s   = gnt_v_s;
        end
      end
    end
  end

  // One-hot grant and operand mux to the evaluator; the operand is zero when idle.
  always_comb begin
    req_ready = '0;
    sig_in    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_v_s && (gnt_idx_s == TAG_W'(i))) begin
        req_ready[i] = 1'b1;
        sig_in       = req_data[i*DATA_W +: DATA_W];
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Next-state logic: pointer, in-flight tag, and response capture/drain.
  // A capture takes priority over a drain in the same cycle.
  always_comb begin
    last_gnt_d     = last_gnt_q;
    inflight_v_d   = gnt_v_s;
    inflight_tag_d = inflight_tag_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    if (gnt_v_s) begin
      last_gnt_d     = gnt_idx_s;
      inflight_tag_d = gnt_idx_s;
    end else begin
      last_gnt_d     = last_gnt_q;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (inflight_v_q && (inflight_tag_q == TAG_W'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = sig_out;
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end else begin
        rsp_valid_d[i] = rsp_valid_q[i];
      end
    end
  end

  // State registers. Reset discards any in-flight op and gives requester 0
  // first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q     <= TAG_W'(NUM_REQ - 1);
      inflight_v_q   <= 1'b0;
      inflight_tag_q <= '0;
      rsp_valid_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      last_gnt_q     <= last_gnt_d;
      inflight_v_q   <= inflight_v_d;
      inflight_tag_q <= inflight_tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  // Flatten the response registers onto the output bus.
  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_data[i*DATA_W +: DATA_W] = rsp_data_q[i];
    end
  end

`ifdef SIGMOID_ARB_STATS_EN
  logic [15:0] stat_grants_q [NUM_REQ];
  logic [15:0] stat_busy_q;

  // Saturating per-requester grant counters and a busy-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_busy_q <= 16'h0000;
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_grants_q[i] <= 16'h0000;
      end
    end else begin
      if (inflight_v_q && (stat_busy_q != 16'hFFFF)) begin
        stat_busy_q <= stat_busy_q + 16'h0001;
      end else begin
        stat_busy_q <= stat_busy_q;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_v_s && (gnt_idx_s == TAG_W'(i)) && (stat_grants_q[i] != 16'hFFFF)) begin
          stat_grants_q[i] <= stat_grants_q[i] + 16'h0001;
        end else begin
          stat_grants_q[i] <= stat_grants_q[i];
        end
      end
    end
  end

  // Flatten the counters onto the statistics ports.
  always_comb begin
    stat_busy   = stat_busy_q;
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[i*16 +: 16] = stat_grants_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter with a registered stand-in evaluator,
// a spec-level transaction model checked every cycle, and pinned expectations.
module tb_sigmoid_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     sig_in;
  logic [W-1:0]     sig_out = '0;
  logic [N-1:0]     rsp_valid;
  logic [N*W-1:0]   rsp_data;
  logic [N-1:0]     rsp_ready = '0;
`ifdef SIGMOID_ARB_STATS_EN
  logic [N*16-1:0]  stat_grants;
  logic [15:0]      stat_busy;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sigmoid_arbiter #(.NUM_REQ(N), .DATA_W(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
`ifdef SIGMOID_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_busy   (stat_busy)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in evaluator: the known sigmoid points, plus a deterministic
  // fallback value for any other operand.
  function automatic logic [31:0] sig_eval(input logic [31:0] x);
    case (x)
      32'h40800000: return 32'h3F700000;
      32'hC0800000: return 32'h3C800000;
      32'h41000000: return 32'h3F800000;
      default:      return 32'h3F000000 ^ {9'd0, x[22:0]};
    endcase
  endfunction

  always @(posedge clk) sig_out <= sig_eval(sig_in);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: pointer, in-flight transaction, and response slots.
  int          m_last = N - 1;
  bit          m_inf_v = 1'b0;
  int          m_inf_tag = 0;
  logic [31:0] m_inf_res = '0;
  bit          m_rv [N];
  logic [31:0] m_rd [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_rv[i] = 1'b0;
      m_rd[i] = '0;
    end
  end

  always @(negedge clk) begin : model_cmp
    int g;
    logic [N-1:0] exp_rdy;
    logic [31:0]  exp_sig;
    g = -1;
    if (!reset) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g < 0 && req_valid[j] && (!m_rv[j] || rsp_ready[j]) && !(m_inf_v && m_inf_tag == j))
          g = j;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    exp_sig = (g >= 0) ? req_data[g*W +: W] : '0;
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("sig_in", sig_in, exp_sig);
      for (int i = 0; i < N; i++) begin
        check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(m_rv[i]));
        check($sformatf("rsp_data[%0d]", i), rsp_data[i*W +: W], m_rd[i]);
      end
    end
    if (reset) begin
      m_last = N - 1; m_inf_v = 1'b0; m_inf_tag = 0;
      for (int i = 0; i < N; i++) begin m_rv[i] = 1'b0; m_rd[i] = '0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_inf_v && m_inf_tag == i) begin
          m_rv[i] = 1'b1; m_rd[i] = m_inf_res;
        end else if (m_rv[i] && rsp_ready[i]) begin
          m_rv[i] = 1'b0;
        end
      end
      m_inf_v = (g >= 0);
      if (g >= 0) begin
        m_inf_tag = g;
        m_inf_res = sig_eval(req_data[g*W +: W]);
        m_last    = g;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] v);
    req_data[i*W +: W] = v;
  endtask

  initial begin
    int ngr;
    reset = 1'b1;
    cyc(); chk_en = 1'b1;
    cyc(); cyc();
    #2;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    cyc(); reset = 1'b0;

    // Single request from requester 0
    req_valid = 4'b0001; set_op(0, 32'h40800000); rsp_ready = 4'b0000;
    #2;
    check("s1_ready", 32'(req_ready), 32'h1);
    check("s1_sig_in", sig_in, 32'h40800000);
    cyc(); req_valid = 4'b0000;
    #2; check("s1_no_early_valid", 32'(rsp_valid), 32'h0);
    cyc();
    #2;
    check("s1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("s1_rsp_data0", rsp_data[31:0], 32'h3F700000);
    rsp_ready = 4'b1111;
    cyc(); #2; check("s1_drained", 32'(rsp_valid), 32'h0);

    // All four continuously valid: one grant per cycle, rotating
    set_op(0, 32'hC0800000); set_op(1, 32'h41000000);
    set_op(2, 32'h40800000); set_op(3, 32'hC0800000);
    cyc(); req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #2; check($sformatf("s2_rr%0d", k), 32'(req_ready), 32'(4'b0001 << ((k + 1) % 4)));
      cyc();
    end
    req_valid = 4'b0000;
    cyc(); cyc(); cyc();
    check("s2_data0", rsp_data[0*W +: W], 32'h3C800000);
    check("s2_data1", rsp_data[1*W +: W], 32'h3F800000);
    check("s2_data2", rsp_data[2*W +: W], 32'h3F700000);
    check("s2_data3", rsp_data[3*W +: W], 32'h3C800000);

    // Backpressure on requester 1
    req_valid = 4'b0010; set_op(1, 32'h3F800000); rsp_ready = 4'b1101;
    #2; check("s3_first_grant", 32'(req_ready), 32'h2);
    cyc(); set_op(1, 32'h40000000);
    #2; check("s3_inflight_block", 32'(req_ready), 32'h0);
    cyc(); #2; check("s3_full_block", 32'(req_ready), 32'h0);
    cyc(); cyc();
    #2;
    check("s3_still_block", 32'(req_ready), 32'h0);
    check("s3_held_valid", 32'(rsp_valid[1]), 32'h1);
    check("s3_held_data", rsp_data[1*W +: W], 32'h3F000000);
    rsp_ready = 4'b1111;
    #1; check("s3_release", 32'(req_ready), 32'h2);
    cyc(); req_valid = 4'b0000;
    cyc(); cyc(); cyc();

    // Same requester only: grant every other cycle
    req_valid = 4'b0100; set_op(2, 32'h41000000);
    ngr = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      check($sformatf("s4_alt%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h4 : 32'h0);
      if (req_ready[2]) ngr++;
      cyc();
    end
    check("s4_grant_count", 32'(ngr), 32'd3);
    req_valid = 4'b0000;
    cyc(); cyc(); cyc();

    // Drain and re-grant requester 3 in the same cycle
    rsp_ready = 4'b0000; req_valid = 4'b1000; set_op(3, 32'hC0800000);
    #2; check("s5_grant_a", 32'(req_ready), 32'h8);
    cyc(); req_valid = 4'b0000;
    cyc();
    #2;
    check("s5_valid_a", 32'(rsp_valid[3]), 32'h1);
    check("s5_data_a", rsp_data[3*W +: W], 32'h3C800000);
    cyc();
    req_valid = 4'b1000; set_op(3, 32'h41000000); rsp_ready = 4'b1000;
    #2; check("s5_grant_b", 32'(req_ready), 32'h8);
    cyc(); req_valid = 4'b0000; rsp_ready = 4'b0000;
    #2; check("s5_drained", 32'(rsp_valid[3]), 32'h0);
    cyc();
    #2;
    check("s5_valid_b", 32'(rsp_valid[3]), 32'h1);
    check("s5_data_b", rsp_data[3*W +: W], 32'h3F800000);
    rsp_ready = 4'b1111;
    cyc(); cyc(); cyc();

    // Reset right after a grant discards the operation
    req_valid = 4'b0001; set_op(0, 32'h40800000);
    #2; check("s6_grant", 32'(req_ready), 32'h1);
    cyc(); req_valid = 4'b0000; reset = 1'b1;
    #2; check("s6_ready_in_reset", 32'(req_ready), 32'h0);
    cyc(); reset = 1'b0; req_valid = 4'b1111;
    #2;
    check("s6_no_rsp", 32'(rsp_valid), 32'h0);
    check("s6_first_req0", 32'(req_ready), 32'h1);
`ifdef SIGMOID_ARB_STATS_EN
    check("s6_stat_grants_clr", stat_grants[31:0], 32'h0);
    check("s6_stat_busy_clr", 32'(stat_busy), 32'h0);
`endif
    for (int k = 1; k <= 8; k++) begin
      cyc(); req_valid = 4'b0001;
    end
    cyc(); req_valid = 4'b0000;
    cyc(); cyc();
    #2;
`ifdef SIGMOID_ARB_STATS_EN
    check("s6_stat_grants0", 32'(stat_grants[15:0]), 32'd5);
    check("s6_stat_grants1", 32'(stat_grants[31:16]), 32'd0);
    check("s6_stat_busy", 32'(stat_busy), 32'd5);
`endif
    check("s6_final_data0", rsp_data[31:0], 32'h3F700000);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
